// File: rtl/can_rx_frame_decoder_pkg.sv
// Shared CAN frame constants, receiver FSM encoding and the decoded-frame record.
package can_rx_frame_decoder_pkg;

  localparam logic [14:0] CRC_POLY  = 15'h4599;
  localparam int          IDLE_BITS = 11;
  localparam int          EOF_BITS  = 7;
  localparam int          ID_A_W    = 11;
  localparam int          ID_B_W    = 18;
  localparam int          DLC_W     = 4;
  localparam int          CRC_W     = 15;

  typedef enum logic [3:0] {
    WAIT_IDLE, IDLE, ID_A, SRR_RTR, IDE, ID_B, RTR, R1, R0,
    DLC, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF
  } state_t;

  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } rx_frame_t;

  // Number of data-field bits: remote frames carry none, DLC above 8 means 8 bytes.
  function automatic logic [6:0] data_bits(input logic rtr, input logic [DLC_W-1:0] dlc);
    if (rtr)            return 7'd0;
    else if (dlc > 4'd8) return 7'd64;
    else                return {dlc, 3'b000};
  endfunction

endpackage

// File: rtl/can_rx_frame_decoder_crc15.sv
// Serial CAN CRC-15; clr and en together restart the register and absorb bit_in.
module can_crc15
  import can_rx_frame_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] base;
  logic             fb;

  always_comb begin
    base = clr ? '0 : crc;
    fb   = bit_in ^ base[CRC_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= '0;
    else if (en)  crc <= {base[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    else if (clr) crc <= '0;
  end

endmodule

// File: rtl/can_rx_frame_decoder.sv
// CAN 2.0B receive path: bus integration, destuffing, field decode, CRC/form checks, ACK request.
module can_rx_frame_decoder
  import can_rx_frame_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_point,
  input  logic        rx_bit,
  input  logic        ack_enable,
  output logic        ack_drive,
  output logic        busy,
  output logic        rx_data_valid,
  output logic [28:0] rx_id,
  output logic        rx_ide,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        stuff_err,
  output logic        crc_err,
  output logic        form_err
);

  state_t           state, state_nxt;
  rx_frame_t        frame_q;
  logic [3:0]       idle_cnt;
  logic [6:0]       cnt;
  logic [2:0]       run_cnt;
  logic             prev_bit;
  logic [CRC_W-1:0] crc_rx, crc_val;

  logic in_stuff, stuff_bit, adv, sof, crc_en, crc_mis;
  logic stuff_viol, form_viol, crc_viol, err, ack_set, frame_done;

  can_crc15 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (sof),
    .en     (crc_en),
    .bit_in (rx_bit),
    .crc    (crc_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sample_point) begin
      case (state)
        WAIT_IDLE: if (rx_bit && idle_cnt == 4'(IDLE_BITS - 1)) state_nxt = IDLE;
        IDLE:      if (!rx_bit) state_nxt = ID_A;
        default:   if (adv) begin
          case (state)
            ID_A:     if (cnt == 7'(ID_A_W - 1)) state_nxt = SRR_RTR;
            SRR_RTR:  state_nxt = IDE;
            IDE:      state_nxt = rx_bit ? ID_B : R0;
            ID_B:     if (cnt == 7'(ID_B_W - 1)) state_nxt = RTR;
            RTR:      state_nxt = R1;
            R1:       state_nxt = R0;
            R0:       state_nxt = DLC;
            DLC:      if (cnt == 7'(DLC_W - 1))
                        state_nxt = (data_bits(frame_q.rtr, {frame_q.dlc[2:0], rx_bit}) == 7'd0)
                                    ? CRC : DATA;
            DATA:     if (cnt == data_bits(frame_q.rtr, frame_q.dlc) - 7'd1) state_nxt = CRC;
            CRC:      if (cnt == 7'(CRC_W - 1)) state_nxt = CRC_DEL;
            CRC_DEL:  state_nxt = ACK_SLOT;
            ACK_SLOT: state_nxt = ACK_DEL;
            ACK_DEL:  state_nxt = EOF;
            EOF:      if (cnt == 7'(EOF_BITS - 1)) state_nxt = IDLE;
            default:  state_nxt = WAIT_IDLE;
          endcase
        end
      endcase
      if (err) state_nxt = WAIT_IDLE;
    end
  end

  // The bit after a CRC run of five is still a stuff bit, so CRC_DEL also honours a pending stuff.
  always_comb begin
    in_stuff   = state inside {ID_A, SRR_RTR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC};
    stuff_bit  = sample_point && run_cnt == 3'd5 && (in_stuff || state == CRC_DEL);
    adv        = sample_point && !stuff_bit;
    sof        = sample_point && state == IDLE && !rx_bit;
    crc_en     = sof || (adv && state inside {ID_A, SRR_RTR, IDE, ID_B, RTR, R1, R0, DLC, DATA});
    crc_mis    = crc_rx != crc_val;
    stuff_viol = stuff_bit && rx_bit == prev_bit;
    form_viol  = adv && !rx_bit && state inside {CRC_DEL, ACK_DEL, EOF};
    crc_viol   = adv && state == CRC_DEL && rx_bit && crc_mis;
    err        = stuff_viol || form_viol || crc_viol;
    ack_set    = adv && state == CRC_DEL && rx_bit && !crc_mis && ack_enable;
    frame_done = adv && state == EOF && rx_bit && cnt == 7'(EOF_BITS - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt      <= '0;
      cnt           <= '0;
      run_cnt       <= '0;
      prev_bit      <= 1'b0;
      crc_rx        <= '0;
      frame_q       <= '0;
      ack_drive     <= 1'b0;
      busy          <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_id         <= '0;
      rx_ide        <= 1'b0;
      rx_rtr        <= 1'b0;
      rx_dlc        <= '0;
      rx_data       <= '0;
      stuff_err     <= 1'b0;
      crc_err       <= 1'b0;
      form_err      <= 1'b0;
    end else begin
      stuff_err     <= stuff_viol;
      form_err      <= form_viol && !stuff_viol;
      crc_err       <= crc_viol && !form_viol && !stuff_viol;
      rx_data_valid <= frame_done;
      if (frame_done) begin
        rx_id   <= frame_q.id;
        rx_ide  <= frame_q.ide;
        rx_rtr  <= frame_q.rtr;
        rx_dlc  <= frame_q.dlc;
        rx_data <= frame_q.data;
      end

      if (sof)                        busy <= 1'b1;
      else if (err || frame_done)     busy <= 1'b0;

      if (err)                        ack_drive <= 1'b0;
      else if (ack_set)               ack_drive <= 1'b1;
      else if (adv && state == ACK_SLOT) ack_drive <= 1'b0;

      if (err)                        idle_cnt <= '0;
      else if (sample_point && state == WAIT_IDLE)
        idle_cnt <= rx_bit ? idle_cnt + 4'd1 : 4'd0;

      if (sof) begin
        prev_bit <= 1'b0;
        run_cnt  <= 3'd1;
      end else if (sample_point && (in_stuff || stuff_bit)) begin
        if (stuff_bit || rx_bit != prev_bit) begin
          prev_bit <= rx_bit;
          run_cnt  <= 3'd1;
        end else begin
          run_cnt <= run_cnt + 3'd1;
        end
      end

      if (adv) cnt <= (state_nxt != state) ? 7'd0 : cnt + 7'd1;

      if (sof) begin
        frame_q <= '0;
        crc_rx  <= '0;
      end else if (adv) begin
        case (state)
          ID_A, ID_B: frame_q.id  <= {frame_q.id[27:0], rx_bit};
          SRR_RTR,
          RTR:        frame_q.rtr <= rx_bit;
          IDE:        frame_q.ide <= rx_bit;
          DLC:        frame_q.dlc <= {frame_q.dlc[2:0], rx_bit};
          DATA:       frame_q.data[6'd63 - cnt[5:0]] <= rx_bit;
          CRC:        crc_rx <= {crc_rx[CRC_W-2:0], rx_bit};
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_rx_frame_decoder.sv
// Scoreboard bench: frames are built and stuffed here, expected outcomes queued and matched on output pulses.
module tb_can_rx_frame_decoder;

  logic        clk = 1'b0;
  logic        rst, sample_point, rx_bit, ack_enable;
  logic        ack_drive, busy, rx_data_valid, rx_ide, rx_rtr;
  logic [28:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        stuff_err, crc_err, form_err;

  can_rx_frame_decoder dut (
    .clk(clk), .rst(rst), .sample_point(sample_point), .rx_bit(rx_bit),
    .ack_enable(ack_enable), .ack_drive(ack_drive), .busy(busy),
    .rx_data_valid(rx_data_valid), .rx_id(rx_id), .rx_ide(rx_ide), .rx_rtr(rx_rtr),
    .rx_dlc(rx_dlc), .rx_data(rx_data), .stuff_err(stuff_err), .crc_err(crc_err),
    .form_err(form_err)
  );

  always #5 clk = ~clk;

  // kind: 0 valid frame, 1 stuff_err, 2 crc_err, 3 form_err
  typedef struct {
    int          kind;
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   bits[$];
  exp_t cur;
  exp_t mon_e;
  int   mon_kind;
  int   n_checks = 0, n_fail = 0;
  int   ack_cycles = 0, busy_cycles = 0, valid_cnt = 0;
  int   gap = 1;

  always @(negedge clk) begin
    if (ack_drive) ack_cycles++;
    if (busy) busy_cycles++;
    if (rx_data_valid) valid_cnt++;
    if (rx_data_valid || stuff_err || crc_err || form_err) begin
      mon_kind = rx_data_valid ? 0 : stuff_err ? 1 : crc_err ? 2 : 3;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: kind=%0d seen, none expected", mon_kind);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_kind != mon_e.kind ||
            $countones({rx_data_valid, stuff_err, crc_err, form_err}) != 1 ||
            (mon_kind == 0 && (rx_id !== mon_e.id || rx_ide !== mon_e.ide || rx_rtr !== mon_e.rtr ||
                               rx_dlc !== mon_e.dlc || rx_data !== mon_e.data))) begin
          n_fail++;
          $display("FAIL scoreboard: got kind=%0d id=%h ide=%b rtr=%b dlc=%h data=%h, expected kind=%0d id=%h ide=%b rtr=%b dlc=%h data=%h",
                   mon_kind, rx_id, rx_ide, rx_rtr, rx_dlc, rx_data,
                   mon_e.kind, mon_e.id, mon_e.ide, mon_e.rtr, mon_e.dlc, mon_e.data);
        end
      end
    end
  end

  task automatic strobe(input bit b);
    rx_bit = b;
    sample_point = 1'b1;
    @(posedge clk); #1;
    sample_point = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle_bits(input int n);
    repeat (n) strobe(1'b1);
  endtask

  task automatic send_bits();
    foreach (bits[i]) strobe(bits[i]);
  endtask

  // Builds the stuffed bit stream SOF..CRC plus delimiters, EOF and intermission; fills cur as the expectation.
  task automatic build_frame(input logic [28:0] id, input bit ide, input bit rtr,
                             input logic [3:0] dlc, input logic [63:0] data, input bit flip_crc);
    bit          raw[$];
    logic [14:0] crc;
    int          nb, run;
    bit          prev, fb;
    crc = '0;
    bits.delete();
    raw.push_back(1'b0);
    if (!ide) begin
      for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
    end else begin
      for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
      raw.push_back(1'b1); raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rtr ? 0 : (dlc > 4'd8 ? 8 : int'(dlc));
    cur.kind = 0;
    cur.id   = ide ? id : {18'b0, id[10:0]};
    cur.ide  = ide;
    cur.rtr  = rtr;
    cur.dlc  = dlc;
    cur.data = '0;
    for (int i = 0; i < nb * 8; i++) begin
      raw.push_back(data[63-i]);
      cur.data[63-i] = data[63-i];
    end
    foreach (raw[i]) begin
      fb  = raw[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    if (flip_crc) crc[7] = ~crc[7];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    prev = 1'b1; run = 0;
    foreach (raw[i]) begin
      bits.push_back(raw[i]);
      if (raw[i] == prev) run++;
      else begin run = 1; prev = raw[i]; end
      if (run == 5) begin bits.push_back(!prev); prev = !prev; run = 1; end
    end
    repeat (13) bits.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_point = 1'b0; rx_bit = 1'b1; ack_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ack_drive, busy, rx_data_valid, stuff_err, crc_err, form_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                         {ack_drive, busy, rx_data_valid, stuff_err, crc_err, form_err});
    end
    n_checks++;
    if ({rx_id, rx_ide, rx_rtr, rx_dlc, rx_data} !== '0) begin
      n_fail++; $display("FAIL reset_fields: got id=%h data=%h expected 0", rx_id, rx_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    idle_bits(11);
  endtask

  task automatic test_base();
    gap = 2; ack_cycles = 0; valid_cnt = 0;
    build_frame(29'h123, 1'b0, 1'b0, 4'd8, 64'hCAFEBABEDEADBEEF, 1'b0);
    exp_q.push_back(cur);
    send_bits();
    n_checks++;
    if (ack_cycles != gap + 1) begin
      n_fail++; $display("FAIL base_ack_width: got %0d cycles expected %0d", ack_cycles, gap + 1);
    end
    n_checks++;
    if (valid_cnt != 1) begin
      n_fail++; $display("FAIL base_valid_count: got %0d expected 1", valid_cnt);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL base_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_extended();
    gap = 0; ack_cycles = 0;
    build_frame(29'h12345678, 1'b1, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0);
    exp_q.push_back(cur);
    send_bits();
    n_checks++;
    if (ack_cycles != 1) begin
      n_fail++; $display("FAIL ext_ack_width: got %0d cycles expected 1", ack_cycles);
    end
  endtask

  task automatic test_remote();
    gap = 1;
    build_frame(29'h7FF, 1'b0, 1'b1, 4'd4, 64'hFFFF_FFFF_0000_0000, 1'b0);
    exp_q.push_back(cur);
    send_bits();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL remote_pending: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_stuff_err();
    gap = 1;
    cur.kind = 1;
    exp_q.push_back(cur);
    repeat (7) strobe(1'b0);
    idle_bits(10);
    busy_cycles = 0;
    strobe(1'b0);
    idle_bits(2);
    n_checks++;
    if (busy_cycles != 0) begin
      n_fail++; $display("FAIL stuff_sof_ignored: busy for %0d cycles expected 0", busy_cycles);
    end
    idle_bits(11);
  endtask

  task automatic test_crc_err();
    gap = 1; ack_cycles = 0;
    build_frame(29'h2AA, 1'b0, 1'b0, 4'd3, 64'h1122_3300_0000_0000, 1'b1);
    cur.kind = 2;
    exp_q.push_back(cur);
    send_bits();
    n_checks++;
    if (ack_cycles != 0) begin
      n_fail++; $display("FAIL crc_ack: got %0d cycles expected 0", ack_cycles);
    end
    n_checks++;
    if (rx_id !== 29'h7FF || rx_rtr !== 1'b1 || rx_dlc !== 4'd4 || rx_data !== 64'h0) begin
      n_fail++; $display("FAIL crc_hold: got id=%h rtr=%b dlc=%h data=%h expected id=7ff rtr=1 dlc=4 data=0",
                         rx_id, rx_rtr, rx_dlc, rx_data);
    end
  endtask

  task automatic test_form_err();
    gap = 1;
    build_frame(29'h0F0, 1'b0, 1'b0, 4'd1, 64'h8100_0000_0000_0000, 1'b0);
    bits[bits.size() - 11] = 1'b0;
    bits.push_back(1'b1); bits.push_back(1'b1);
    cur.kind = 3;
    exp_q.push_back(cur);
    send_bits();
    n_checks++;
    if (rx_id !== 29'h7FF) begin
      n_fail++; $display("FAIL form_hold: got id=%h expected 7ff", rx_id);
    end
  endtask

  task automatic test_back_to_back();
    gap = 1; ack_cycles = 0;
    ack_enable = 1'b0;
    build_frame(29'h000, 1'b0, 1'b0, 4'd0, 64'h0, 1'b0);
    exp_q.push_back(cur);
    send_bits();
    build_frame(29'h5A5, 1'b0, 1'b0, 4'd12, 64'hFFFF_0000_FFFF_0000, 1'b0);
    exp_q.push_back(cur);
    send_bits();
    n_checks++;
    if (ack_cycles != 0) begin
      n_fail++; $display("FAIL b2b_no_ack: got %0d cycles expected 0", ack_cycles);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_pending: got %0d outstanding expected 0", exp_q.size());
    end
    ack_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    gap = 1;
    build_frame(29'h321, 1'b0, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b0);
    for (int i = 0; i < 30; i++) strobe(bits[i]);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ack_drive, busy, rx_data_valid, stuff_err, crc_err, form_err, rx_id, rx_ide, rx_rtr, rx_dlc, rx_data} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got busy=%b id=%h dlc=%h data=%h expected all 0",
                         busy, rx_id, rx_dlc, rx_data);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    idle_bits(11);
    build_frame(29'h055, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 1'b0);
    exp_q.push_back(cur);
    send_bits();
    n_checks++;
    if (rx_id !== 29'h055 || rx_data[63:56] !== 8'h3C) begin
      n_fail++; $display("FAIL mid_second_frame: got id=%h byte0=%h expected id=055 byte0=3c",
                         rx_id, rx_data[63:56]);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_extended();
    test_remote();
    test_stuff_err();
    test_crc_err();
    test_form_err();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL final_pending: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
